// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : draw_pkg
//  Purpose  : Shared definitions for the draw sequencer: FSM state encoding,
//             command mode codes, xySel codes and well-known start slots.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package draw_pkg;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_INIT       = 4'd1,
      ST_ARM        = 4'd2,
      ST_DRAW       = 4'd3,
      ST_HOLD       = 4'd4,
      ST_ERASE_INIT = 4'd5,
      ST_ERASE_ARM  = 4'd6,
      ST_ERASE      = 4'd7,
      ST_STEP       = 4'd8,
      ST_FIN        = 4'd9
   } drawState_t;

   localparam logic [1:0] MODE_SCREEN = 2'd0;
   localparam logic [1:0] MODE_SPRITE = 2'd1;
   localparam logic [1:0] MODE_ANIM   = 2'd2;

   localparam logic [1:0] XY_INIT   = 2'b00;
   localparam logic [1:0] XY_SCREEN = 2'b01;
   localparam logic [1:0] XY_WIN    = 2'b10;

   localparam logic [4:0] XSEL_MOVE_FIRST = 5'd14;
   localparam logic [4:0] XSEL_MOVE_LAST  = 5'd21;
   localparam logic [1:0] YSEL_BATTLE     = 2'd1;

   // The unused mode code 3 is folded onto sprite at command accept so the
   // FSM only ever sees the three real modes.
   function automatic logic [1:0] normMode(input logic [1:0] mode);
      return (mode == 2'd3) ? MODE_SPRITE : mode;
   endfunction

endpackage
`default_nettype wire

// File: rtl/draw_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : draw_sequencer_if
//  Purpose  : Bundles the command handshake from the game FSM and the
//             control/status lines to the pixel datapath.
//  Modports : slave  - the sequencer (takes commands, drives datapath)
//             master - the game FSM / datapath side
//  Revision : 1.0  initial release
// ============================================================================
interface draw_sequencer_if;
   // command side
   logic       req;
   logic [1:0] cmd_mode;
   logic [4:0] cmd_xsel;
   logic [4:0] cmd_xend;
   logic [1:0] cmd_ysel;
   logic [4:0] cmd_mem;
   logic       cmd_black;
   logic       busy;
   logic       done;
   // datapath side
   logic       screenDone;
   logic [4:0] xInitSel;
   logic [1:0] yInitSel;
   logic       xInitLoad;
   logic       yInitLoad;
   logic [1:0] xySel;
   logic       xLoad;
   logic       yLoad;
   logic       xCountUp;
   logic       yCountUp;
   logic [4:0] memorySel;
   logic       black;
   logic       plot;

   modport slave (
      input  req, cmd_mode, cmd_xsel, cmd_xend, cmd_ysel, cmd_mem, cmd_black,
      input  screenDone,
      output busy, done, xInitSel, yInitSel, xInitLoad, yInitLoad, xySel,
      output xLoad, yLoad, xCountUp, yCountUp, memorySel, black, plot
   );

   modport master (
      output req, cmd_mode, cmd_xsel, cmd_xend, cmd_ysel, cmd_mem, cmd_black,
      output screenDone,
      input  busy, done, xInitSel, yInitSel, xInitLoad, yInitLoad, xySel,
      input  xLoad, yLoad, xCountUp, yCountUp, memorySel, black, plot
   );
endinterface
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_timer
//  Purpose  : One-shot cycle counter for the animation frame hold.
//             A start pulse arms it; it then runs 0..FRAME_TICKS-1 and
//             flags expire during its last count, clearing itself after.
//  Ports    : clk, resetn (async active-low), start (pulse), expire (out)
//  Revision : 1.0  initial release
// ============================================================================
module frame_timer #(
   parameter int FRAME_TICKS = 2_500_000,
   parameter int TICK_W      = 22
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   output logic expire
);

   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);

   logic [TICK_W-1:0] tickCount;
   logic              running;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tickCount <= '0;
         running   <= 1'b0;
      end else if (start) begin
         tickCount <= '0;
         running   <= 1'b1;
      end else if (running) begin
         if (tickCount == LAST_TICK) begin
            tickCount <= '0;
            running   <= 1'b0;
         end else begin
            tickCount <= tickCount + 1'b1;
         end
      end
   end

   assign expire = running && (tickCount == LAST_TICK);

endmodule
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : draw_sequencer
//  Purpose  : Control FSM for the pixel-drawing datapath. Accepts one draw
//             command at a time (full screen, 40x40 sprite, or stepped
//             sprite animation with erase between frames) and issues the
//             start-point, scan-register, colour-mux and plot strobes.
//  Ports    : clk        system clock
//             resetn     asynchronous active-low reset
//             bus        draw_sequencer_if.slave (command + datapath lines)
//  Revision : 1.0  initial release
// ============================================================================
module draw_sequencer
   import draw_pkg::*;
#(
   parameter int FRAME_TICKS = 2_500_000,
   parameter int TICK_W      = 22
) (
   input  logic             clk,
   input  logic             resetn,
   draw_sequencer_if.slave  bus
);

   drawState_t state, nextState;

   // latched command; curXsel doubles as the animation slot pointer
   logic [1:0] latMode;
   logic [4:0] curXsel;
   logic [4:0] latXend;
   logic [1:0] latYsel;
   logic [4:0] latMem;
   logic       latBlack;

   logic holdStart;
   logic holdExpire;
   logic isScreen;
   logic scanning;

   assign isScreen = (latMode == MODE_SCREEN);

   frame_timer #(
      .FRAME_TICKS (FRAME_TICKS),
      .TICK_W      (TICK_W)
   ) uHoldTimer (
      .clk    (clk),
      .resetn (resetn),
      .start  (holdStart),
      .expire (holdExpire)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         latMode  <= MODE_SCREEN;
         curXsel  <= '0;
         latXend  <= '0;
         latYsel  <= '0;
         latMem   <= '0;
         latBlack <= 1'b0;
      end else begin
         state <= nextState;
         if (state == ST_IDLE && bus.req) begin
            latMode  <= normMode(bus.cmd_mode);
            curXsel  <= bus.cmd_xsel;
            latXend  <= bus.cmd_xend;
            latYsel  <= bus.cmd_ysel;
            latMem   <= bus.cmd_mem;
            latBlack <= bus.cmd_black;
         end else if (state == ST_STEP) begin
            curXsel <= curXsel + 5'd1;   // natural 5-bit wrap 31 -> 0
         end
      end
   end

   always_comb begin
      nextState     = state;
      holdStart     = 1'b0;
      scanning      = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.xInitSel  = '0;
      bus.yInitSel  = '0;
      bus.xInitLoad = 1'b0;
      bus.yInitLoad = 1'b0;
      bus.xySel     = XY_INIT;
      bus.xLoad     = 1'b0;
      bus.yLoad     = 1'b0;
      bus.xCountUp  = 1'b0;
      bus.yCountUp  = 1'b0;
      bus.memorySel = '0;
      bus.black     = 1'b0;
      bus.plot      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (bus.req) nextState = ST_INIT;
         end

         ST_INIT, ST_ERASE_INIT: begin
            bus.busy      = 1'b1;
            // full screen always starts at the origin slot
            bus.xInitSel  = isScreen ? 5'd0 : curXsel;
            bus.yInitSel  = isScreen ? 2'd0 : latYsel;
            bus.xInitLoad = 1'b1;
            bus.yInitLoad = 1'b1;
            nextState     = (state == ST_INIT) ? ST_ARM : ST_ERASE_ARM;
         end

         ST_ARM, ST_ERASE_ARM: begin
            bus.busy  = 1'b1;
            bus.xySel = XY_INIT;
            bus.xLoad = 1'b1;
            bus.yLoad = 1'b1;
            nextState = (state == ST_ARM) ? ST_DRAW : ST_ERASE;
         end

         ST_DRAW, ST_ERASE: begin
            bus.busy      = 1'b1;
            scanning      = !bus.screenDone;
            bus.xySel     = isScreen ? XY_SCREEN : XY_WIN;
            bus.xLoad     = scanning;
            bus.yLoad     = scanning;
            bus.xCountUp  = scanning;
            bus.yCountUp  = scanning;
            bus.plot      = scanning;
            bus.memorySel = latMem;
            bus.black     = (state == ST_ERASE) ? 1'b1 : latBlack;
            if (bus.screenDone) begin
               if (state == ST_ERASE) begin
                  nextState = ST_STEP;
               end else if (latMode == MODE_ANIM && curXsel != latXend) begin
                  nextState = ST_HOLD;
                  holdStart = 1'b1;
               end else begin
                  nextState = ST_FIN;
               end
            end
         end

         ST_HOLD: begin
            bus.busy = 1'b1;
            if (holdExpire) nextState = ST_ERASE_INIT;
         end

         ST_STEP: begin
            bus.busy  = 1'b1;
            nextState = ST_INIT;
         end

         ST_FIN: begin
            bus.done  = 1'b1;
            nextState = ST_IDLE;
         end

         default: nextState = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_sequencer
//  Purpose  : Directed self-checking bench for draw_sequencer. A small x/y
//             scan model answers screenDone (160x120 full screen, 40x40
//             window); a negedge monitor tallies plots, dones, INIT loads
//             and idle-strobe run lengths (HOLD / STEP) for each scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_draw_sequencer;
   import draw_pkg::*;

   localparam int TB_TICKS = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   draw_sequencer_if bus ();

   draw_sequencer #(
      .FRAME_TICKS (TB_TICKS),
      .TICK_W      (22)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int passCnt  = 0;
   int checkCnt = 0;

   // ---------------- datapath scan model ----------------
   logic [7:0] mx, my;
   logic       forceDone = 1'b0;
   logic       modelDone;

   assign modelDone      = (bus.xySel == XY_SCREEN) ? (my == 8'd120) : (my == 8'd40);
   assign bus.screenDone = forceDone | modelDone;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mx <= '0;
         my <= '0;
      end else if (bus.xySel == XY_INIT && bus.xLoad) begin
         mx <= '0;
         my <= '0;
      end else if (bus.xCountUp) begin
         if (mx == ((bus.xySel == XY_SCREEN) ? 8'd159 : 8'd39)) begin
            mx <= '0;
            my <= my + 8'd1;
         end else begin
            mx <= mx + 8'd1;
         end
      end
   end

   // ---------------- monitor ----------------
   int plotCnt, blackPlots, goodPlots, doneCnt, initCnt, runLen, screenPlots;
   logic [4:0] initXQ[$];
   logic [1:0] initYQ[$];
   int         runQ[$];
   logic       idleStrobe;

   assign idleStrobe = bus.busy && bus.xySel == XY_INIT && !bus.xLoad && !bus.xInitLoad;

   task automatic clearMon();
      plotCnt = 0; blackPlots = 0; goodPlots = 0; doneCnt = 0;
      initCnt = 0; runLen = 0; screenPlots = 0;
      initXQ.delete(); initYQ.delete(); runQ.delete();
   endtask

   always @(negedge clk) begin
      if (resetn) begin
         if (bus.plot) begin
            plotCnt++;
            if (bus.black) blackPlots++;
            if (bus.xySel == XY_SCREEN) screenPlots++;
         end
         if (bus.plot && !bus.black && bus.memorySel == 5'd12) goodPlots++;
         if (bus.done) doneCnt++;
         if (bus.xInitLoad && bus.yInitLoad) begin
            initCnt++;
            initXQ.push_back(bus.xInitSel);
            initYQ.push_back(bus.yInitSel);
         end
         if (idleStrobe) runLen++;
         else if (runLen > 0) begin
            runQ.push_back(runLen);
            runLen = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic sendCmd(input logic [1:0] mode, input logic [4:0] xs, input logic [4:0] xe,
                          input logic [1:0] ys, input logic [4:0] mem, input logic blk);
      bus.cmd_mode = mode; bus.cmd_xsel = xs; bus.cmd_xend = xe;
      bus.cmd_ysel = ys; bus.cmd_mem = mem; bus.cmd_black = blk;
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
   endtask

   task automatic waitDone(input int maxCyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < maxCyc; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checkCnt++;
      if ({bus.busy, bus.done, bus.plot} !== 3'b000) $display("FAIL reset_status busy/done/plot=%b required 000", {bus.busy, bus.done, bus.plot});
      else passCnt++;
      checkCnt++;
      if ({bus.xInitLoad, bus.yInitLoad, bus.xLoad, bus.yLoad, bus.xCountUp, bus.yCountUp, bus.xySel, bus.memorySel, bus.black} !== 13'd0)
         $display("FAIL reset_strobes got nonzero strobes/selects required all 0");
      else passCnt++;
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_screen();
      bit seen;
      clearMon();
      sendCmd(MODE_SCREEN, 5'd5, 5'd0, 2'd2, 5'd2, 1'b0);
      checkCnt++;
      if (!(bus.busy && bus.xInitLoad && bus.yInitLoad && bus.xInitSel == 5'd0 && bus.yInitSel == 2'd0))
         $display("FAIL fs_init busy=%b xIL=%b xInitSel=%0d yInitSel=%0d required 1,1,0,0", bus.busy, bus.xInitLoad, bus.xInitSel, bus.yInitSel);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (!(bus.xySel == XY_INIT && bus.xLoad && bus.yLoad && !bus.plot && !bus.xInitLoad))
         $display("FAIL fs_arm xySel=%b xLoad=%b yLoad=%b plot=%b required 00,1,1,0", bus.xySel, bus.xLoad, bus.yLoad, bus.plot);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (!(bus.xySel == XY_SCREEN && bus.plot && bus.xCountUp && bus.yCountUp && bus.memorySel == 5'd2 && !bus.black))
         $display("FAIL fs_draw xySel=%b plot=%b mem=%0d black=%b required 01,1,2,0", bus.xySel, bus.plot, bus.memorySel, bus.black);
      else passCnt++;
      seen = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (bus.screenDone) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      checkCnt++;
      if (!(seen && !bus.plot && !bus.xLoad)) $display("FAIL fs_scan_end seen=%b plot=%b required seen=1 plot=0", seen, bus.plot);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (!(bus.done && !bus.busy)) $display("FAIL fs_done done=%b busy=%b required 1,0", bus.done, bus.busy);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (bus.done || bus.busy || plotCnt != 19200)
         $display("FAIL fs_after done=%b busy=%b plots=%0d required 0,0,19200", bus.done, bus.busy, plotCnt);
      else passCnt++;
   endtask

   task automatic test_sprite();
      bit seen;
      clearMon();
      sendCmd(MODE_SPRITE, 5'd8, 5'd0, 2'd1, 5'd12, 1'b0);
      waitDone(3000, seen);
      @(posedge clk); #1;
      checkCnt++;
      if (!(seen && plotCnt == 1600 && goodPlots == 1600 && doneCnt == 1))
         $display("FAIL sprite seen=%b plots=%0d good=%0d dones=%0d required 1,1600,1600,1", seen, plotCnt, goodPlots, doneCnt);
      else passCnt++;
      checkCnt++;
      if (!(initCnt == 1 && initXQ[0] == 5'd8 && initYQ[0] == 2'd1))
         $display("FAIL sprite_init inits=%0d x=%0d y=%0d required 1,8,1", initCnt, initXQ[0], initYQ[0]);
      else passCnt++;
   endtask

   task automatic test_animate();
      bit seen, bad;
      logic [4:0] expX [5];
      expX = '{5'd14, 5'd14, 5'd15, 5'd15, 5'd16};
      clearMon();
      sendCmd(MODE_ANIM, XSEL_MOVE_FIRST, 5'd16, 2'd2, 5'd7, 1'b0);
      waitDone(12000, seen);
      @(posedge clk); #1;
      bad = (initXQ.size() != 5);
      if (!bad) for (int i = 0; i < 5; i++) if (initXQ[i] != expX[i] || initYQ[i] != 2'd2) bad = 1'b1;
      checkCnt++;
      if (!seen || bad) $display("FAIL anim_slots seen=%b inits=%0d required 5 inits 14,14,15,15,16 y=2", seen, initXQ.size());
      else passCnt++;
      checkCnt++;
      if (!(runQ.size() == 4 && runQ[0] == TB_TICKS && runQ[1] == 1 && runQ[2] == TB_TICKS && runQ[3] == 1))
         $display("FAIL anim_hold runs=%0d first=%0d required 4 runs 4,1,4,1", runQ.size(), (runQ.size() > 0) ? runQ[0] : -1);
      else passCnt++;
      checkCnt++;
      if (!(plotCnt == 8000 && blackPlots == 3200 && doneCnt == 1))
         $display("FAIL anim_plots plots=%0d black=%0d dones=%0d required 8000,3200,1", plotCnt, blackPlots, doneCnt);
      else passCnt++;
   endtask

   task automatic test_back_to_back();
      bit seen;
      clearMon();
      bus.cmd_mode = MODE_SPRITE; bus.cmd_xsel = 5'd3; bus.cmd_xend = 5'd0;
      bus.cmd_ysel = 2'd0; bus.cmd_mem = 5'd12; bus.cmd_black = 1'b0;
      bus.req = 1'b1;
      waitDone(4000, seen);
      checkCnt++;
      if (!(seen && initCnt == 1)) $display("FAIL b2b_first seen=%b inits=%0d required 1,1", seen, initCnt);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (bus.busy || bus.xInitLoad) $display("FAIL b2b_idle busy=%b xIL=%b required 0,0", bus.busy, bus.xInitLoad);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (!(bus.busy && bus.xInitLoad)) $display("FAIL b2b_accept busy=%b xIL=%b required 1,1", bus.busy, bus.xInitLoad);
      else passCnt++;
      bus.req = 1'b0;
      waitDone(4000, seen);
      @(posedge clk); #1;
      checkCnt++;
      if (!(seen && initCnt == 2 && doneCnt == 2)) $display("FAIL b2b_second seen=%b inits=%0d dones=%0d required 1,2,2", seen, initCnt, doneCnt);
      else passCnt++;
   endtask

   task automatic test_reset_mid_draw();
      bit seen;
      clearMon();
      sendCmd(MODE_SPRITE, 5'd2, 5'd0, 2'd3, 5'd12, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      checkCnt++;
      if (!bus.plot) $display("FAIL rst_pre plot=%b required 1", bus.plot);
      else passCnt++;
      #2 resetn = 1'b0;
      #1;
      checkCnt++;
      if ({bus.busy, bus.done, bus.plot, bus.xLoad, bus.yLoad, bus.xCountUp, bus.yCountUp, bus.xySel, bus.memorySel, bus.black} !== 15'd0)
         $display("FAIL rst_async busy=%b plot=%b xySel=%b mem=%0d required all 0", bus.busy, bus.plot, bus.xySel, bus.memorySel);
      else passCnt++;
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkCnt++;
      if (doneCnt != 0 || bus.busy) $display("FAIL rst_nodone dones=%0d busy=%b required 0,0", doneCnt, bus.busy);
      else passCnt++;
      sendCmd(MODE_SPRITE, 5'd2, 5'd0, 2'd3, 5'd12, 1'b0);
      waitDone(3000, seen);
      @(posedge clk); #1;
      checkCnt++;
      if (!(seen && doneCnt == 1)) $display("FAIL rst_recover seen=%b dones=%0d required 1,1", seen, doneCnt);
      else passCnt++;
   endtask

   task automatic test_zero_plot();
      clearMon();
      forceDone = 1'b1;
      sendCmd(MODE_SPRITE, 5'd1, 5'd0, 2'd0, 5'd12, 1'b0);
      @(posedge clk); #1;   // ARM
      @(posedge clk); #1;   // DRAW, scan already finished
      checkCnt++;
      if (!(bus.xySel == XY_WIN && !bus.plot && !bus.xCountUp && bus.busy))
         $display("FAIL zero_draw xySel=%b plot=%b busy=%b required 10,0,1", bus.xySel, bus.plot, bus.busy);
      else passCnt++;
      @(posedge clk); #1;
      checkCnt++;
      if (!(bus.done && plotCnt == 0)) $display("FAIL zero_done done=%b plots=%0d required 1,0", bus.done, plotCnt);
      else passCnt++;
      forceDone = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      bit seen;
      clearMon();
      sendCmd(MODE_ANIM, 5'd31, 5'd0, 2'd0, 5'd5, 1'b0);
      waitDone(8000, seen);
      @(posedge clk); #1;
      checkCnt++;
      if (!(seen && initXQ.size() == 3 && initXQ[0] == 5'd31 && initXQ[1] == 5'd31 && initXQ[2] == 5'd0))
         $display("FAIL wrap_slots seen=%b inits=%0d required 3 inits 31,31,0", seen, initXQ.size());
      else passCnt++;
      checkCnt++;
      if (!(plotCnt == 4800 && blackPlots == 1600 && runQ.size() == 2))
         $display("FAIL wrap_plots plots=%0d black=%0d runs=%0d required 4800,1600,2", plotCnt, blackPlots, runQ.size());
      else passCnt++;
   endtask

   task automatic test_mode3();
      bit seen;
      clearMon();
      sendCmd(2'd3, 5'd4, 5'd9, 2'd3, 5'd12, 1'b0);
      waitDone(3000, seen);
      @(posedge clk); #1;
      checkCnt++;
      if (!(seen && plotCnt == 1600 && goodPlots == 1600 && screenPlots == 0 && runQ.size() == 0 && initCnt == 1 && initXQ[0] == 5'd4))
         $display("FAIL mode3 seen=%b plots=%0d good=%0d screen=%0d runs=%0d inits=%0d required 1,1600,1600,0,0,1",
                  seen, plotCnt, goodPlots, screenPlots, runQ.size(), initCnt);
      else passCnt++;
   endtask

   initial begin
      bus.req = 1'b0; bus.cmd_mode = '0; bus.cmd_xsel = '0; bus.cmd_xend = '0;
      bus.cmd_ysel = '0; bus.cmd_mem = '0; bus.cmd_black = 1'b0;
      clearMon();
      test_reset();
      test_full_screen();
      test_sprite();
      test_animate();
      test_back_to_back();
      test_reset_mid_draw();
      test_zero_plot();
      test_wrap();
      test_mode3();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/draw_sequencer.md
# draw_sequencer

Control FSM that drives the pixel-drawing datapath: the x/y start-point registers, the x/y scan registers and the colour mux. It accepts one draw command at a time from the game FSM and issues the datapath's select, load and count strobes plus the VGA plot strobe. It supports three command modes: full-screen fill, a single 40x40 sprite, and a stepped sprite animation with erase between frames.

## Interface
- FRAME_TICKS, 2_500_000: clk cycles a drawn animation frame is held before erase (50 MHz / 20).
- TICK_W, 22: width of the frame-hold counter; must hold FRAME_TICKS-1.
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  command request; sampled only in IDLE.
- cmd_mode  in  2  0 = full screen, 1 = sprite, 2 = animate; 3 is treated as 1.
- cmd_xsel  in  5  start xInitSel slot.
- cmd_xend  in  5  last xInitSel slot (animate only).
- cmd_ysel  in  2  yInitSel value.
- cmd_mem  in  5  memorySel for the drawn image.
- cmd_black  in  1  draw in black (erase/clear).
- screenDone  in  1  from the scan register; 1 = scan finished.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse when a command completes.
- xInitSel  out  5 / yInitSel  out  2  start-point selects.
- xInitLoad, yInitLoad  out  1  start-point register enables.
- xySel  out  2  00 = load init, 01 = full screen, 10 = 40x40 window.
- xLoad, yLoad, xCountUp, yCountUp  out  1  scan register strobes.
- memorySel  out  5 / black  out  1  colour-mux controls.
- plot  out  1  VGA write enable.

## Operation
- States: IDLE, INIT, ARM, DRAW, HOLD, ERASE_INIT, ERASE_ARM, ERASE, STEP, FIN.
- IDLE: when req=1, latch all cmd_* fields, set busy, and go to INIT. req is ignored in every other state.
- INIT: drive the latched xsel and ysel and assert xInitLoad and yInitLoad for one cycle. For full screen, force xsel=0 and ysel=0. Next state is ARM.
- ARM: xySel=00, xLoad=yLoad=1 (copies the init point into x/y). Next state is DRAW.
- DRAW: xySel=01 for full screen, otherwise 10. xLoad, yLoad, xCountUp and yCountUp equal !screenDone. plot equals !screenDone. memorySel and black take the latched values.
  - On screenDone=1: go to FIN for full screen and sprite. For animate, go to FIN if cur_xsel==xend, otherwise go to HOLD.
- HOLD: count FRAME_TICKS cycles, then go to ERASE_INIT.
- ERASE_INIT, ERASE_ARM and ERASE mirror INIT, ARM and DRAW with black=1. On screenDone, go to STEP.
- STEP: cur_xsel is incremented by 1 (5-bit wrap). Next state is INIT.
- FIN: done=1, busy=0. Next state is IDLE.
- Animate with cmd_xsel==cmd_xend behaves as a sprite: one frame, no erase.
- Animate with xend < xsel steps through the wrap: 31 -> 0.
- In every state other than DRAW and ERASE, the strobes not listed for that state are 0.

## Timing
- Reset (async assert): state=IDLE. All outputs are 0, including busy, done and plot. The latched command and the tick counter are cleared. No done is issued for an aborted command.
- Accept latency: req high in IDLE -> INIT on the next edge. busy rises on that same edge.
- Overhead per frame: INIT plus ARM, i.e. 2 cycles before the first plot.
- DRAW length equals the number of cycles screenDone stays 0.
- FIN to IDLE takes 1 cycle. A new req is accepted earliest the cycle after done.
- HOLD lasts exactly FRAME_TICKS cycles. The counter runs 0..FRAME_TICKS-1 and resets on exit.
- screenDone arriving in the first DRAW cycle means zero plots and an immediate transition.

## Structure
- Shared package draw_pkg holds:
  - the state encoding;
  - mode codes MODE_SCREEN=0, MODE_SPRITE=1, MODE_ANIM=2;
  - xySel codes XY_INIT=00, XY_SCREEN=01, XY_WIN=10;
  - slot constants XSEL_MOVE_FIRST=14, XSEL_MOVE_LAST=21, YSEL_BATTLE=1.
- One sub-module, frame_timer (TICK_W-bit, with start and expire), for the HOLD delay.

## Test plan
- Full screen: req with mode=0, mem=2. Expect INIT with xInitSel=0 and yInitSel=0, then ARM with xySel=00, then DRAW with xySel=01 and plot=1 until screenDone. Expect done 1 cycle after screenDone and busy low thereafter.
- Sprite: mode=1, xsel=8, ysel=1, mem=12, with a datapath model. Expect 40x40 plots with memorySel=12, black=0, and exactly one done.
- Animate: mode=2, xsel=14, xend=16, FRAME_TICKS=4. Expect draw/hold/erase at slots 14 and 15, final draw at slot 16, no final erase, and hold intervals of exactly 4 cycles.
- req is asserted continuously while busy. The second command is accepted only after FIN, so exactly one INIT follows each done.
- resetn is pulled low mid-DRAW. All outputs go to 0 asynchronously, no done is issued, and after release req is accepted normally.
- Edge cases:
  - screenDone=1 on the first DRAW cycle gives zero plot cycles.
  - xsel=31, xend=0 steps through the wrap to 0.
  - mode=3 behaves as a sprite.
